// File: rtl/uart_tx_mmio_pkg.sv
// rtl/uart_tx_mmio_pkg.sv - shared register map, status layout and serializer states
package uart_tx_mmio_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1000_0000;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    function automatic logic [3:0] sat_count4(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// rtl/uart_tx_mmio_sync_fifo.sv - synchronous FIFO with fall-through head data
module uart_tx_mmio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + 1'b1;
            end else if (pop_i && !push_i) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status register
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEFAULT,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        tx,
    output logic        irq_empty
);

    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          irq_empty_q;
    logic          overflow_q;
    logic          overflow_d;

    logic          sel;
    logic [1:0]    reg_sel;
    logic          push_req;
    logic          status_wr;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          bit_done;
    logic [31:0]   status;
    logic          unused_bits;

    assign sel       = (mem_address[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = mem_address[3:2];
    assign push_req  = mem_write && sel && (reg_sel == REG_TXDATA);
    assign status_wr = mem_write && sel && (reg_sel == REG_STATUS);
    assign bit_done  = (baud_q == BAUD_LAST);

    // Popping is decided from registered state so the FSM and FIFO agree in the same cycle.
    assign fifo_pop  = !fifo_empty &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));
    assign fifo_push = push_req && (!fifo_full || fifo_pop);

    uart_tx_mmio_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (data_in[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (push_req && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end else if (status_wr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            irq_empty_q <= 1'b1;
        end else begin
            irq_empty_q <= fifo_empty && (state_q == S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (fifo_pop) begin
                        shift_q <= fifo_head;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        baud_q <= '0;
                        if (fifo_pop) begin
                            shift_q <= fifo_head;
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        status                            = 32'h0;
        status[ST_BUSY]                   = (state_q != S_IDLE);
        status[ST_FULL]                   = fifo_full;
        status[ST_EMPTY]                  = fifo_empty;
        status[ST_OVF]                    = overflow_q;
        status[ST_CNT_LSB+3:ST_CNT_LSB]   = sat_count4(32'(fifo_count));
    end

    // Zero when unselected so the core can OR this with data memory's read data.
    always_comb begin
        data_out = 32'h0;
        if (mem_read && sel && (reg_sel == REG_STATUS)) begin
            data_out = status;
        end
    end

    assign unused_bits = ^{mem_address[1:0], data_in[31:8]};

    assign tx        = tx_q;
    assign irq_empty = irq_empty_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] mem_address;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        tx;
    logic        irq_empty;

    int n_checks;
    int n_fail;

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_address (mem_address),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .data_in     (data_in),
        .data_out    (data_out),
        .tx          (tx),
        .irq_empty   (irq_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
        mem_address = addr;
        data_in     = data;
        mem_write   = 1'b1;
        step(1);
        mem_write   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        mem_address = addr;
        mem_read    = 1'b1;
        #1;
        check(tag, data_out, exp);
        mem_read    = 1'b0;
    endtask

    // cur_off: current negedge offset relative to the first start-bit cycle of this frame
    task automatic check_frame(input logic [7:0] b, input int cur_off, input int exp_st);
        int cur;
        cur = cur_off;
        if (cur < 0) begin
            step(-cur);
            cur = 0;
            check($sformatf("gap_before_%h", b), tx, 0);
        end
        for (int k = 0; k < 10; k++) begin
            int   tgt;
            logic e;
            tgt = 4 * k + 2;
            if (tgt < cur) continue;
            step(tgt - cur);
            cur = tgt;
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            check($sformatf("frame_%h_bit%0d", b, k), tx, e);
            if (k == 1 && exp_st >= 0) begin
                read_check($sformatf("frame_%h_status", b), BASE + 4, exp_st);
            end
        end
    endtask

    task automatic quiet(input string tag, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            step(1);
            if (tx !== 1'b1) lows++;
        end
        check(tag, lows, 0);
    endtask

    initial begin
        logic [7:0] six [6];
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        mem_address = 32'h0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        data_in     = 32'h0;
        six = '{8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E};

        // 1: reset
        step(3);
        rst = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_irq", irq_empty, 1);
        read_check("rst_status", BASE + 4, 32'h0000_0004);
        step(2);

        // 2: single frame, latency and irq
        write_reg(BASE, 32'hFFFF_FFA5);
        check("t2_tx_cycle1", tx, 1);
        step(1);
        check("t2_tx_cycle2", tx, 0);
        check("t2_irq_busy", irq_empty, 0);
        check_frame(8'hA5, 0, -1);
        step(8);
        check("t2_irq_after", irq_empty, 1);
        read_check("t2_status_after", BASE + 4, 32'h0000_0004);

        // 3: three back-to-back frames
        write_reg(BASE, 32'h11);
        write_reg(BASE, 32'h22);
        write_reg(BASE, 32'h33);
        check_frame(8'h11, 1, 32'h21);
        check_frame(8'h22, -2, 32'h11);
        check_frame(8'h33, -2, 32'h05);
        step(8);

        // 4: overflow, sticky flag and clear
        for (int i = 0; i < 6; i++) write_reg(BASE, {24'h0, six[i]});
        read_check("t4_status_ovf", BASE + 4, 32'h0000_004B);
        write_reg(BASE + 4, 32'h0);
        read_check("t4_status_clr", BASE + 4, 32'h0000_0043);
        check_frame(six[0], 5, -1);
        for (int i = 1; i < 5; i++) check_frame(six[i], -2, -1);
        step(8);
        read_check("t4_status_end", BASE + 4, 32'h0000_0004);
        quiet("t4_no_sixth", 40);

        // 5: reset in the middle of DATA
        write_reg(BASE, 32'h5A);
        write_reg(BASE, 32'h66);
        check("t5_start", tx, 0);
        step(14);
        rst = 1'b1;
        step(1);
        check("t5_tx_rst", tx, 1);
        check("t5_irq_rst", irq_empty, 1);
        rst = 1'b0;
        read_check("t5_status", BASE + 4, 32'h0000_0004);
        quiet("t5_quiet", 60);

        // 6: unmapped registers and out-of-window accesses
        read_check("t6_rd_reg2", BASE + 8, 32'h0);
        read_check("t6_rd_txdata", BASE, 32'h0);
        read_check("t6_rd_outside", 32'h2000_0004, 32'h0);
        read_check("t6_rd_next_window", 32'h1000_0014, 32'h0);
        mem_address = BASE + 4;
        #1;
        check("t6_no_read_strobe", data_out, 32'h0);
        write_reg(BASE + 8, 32'h77);
        write_reg(BASE + 12, 32'h78);
        write_reg(32'h2000_0000, 32'h99);
        write_reg(32'h1000_0010, 32'h9A);
        read_check("t6_status", BASE + 4, 32'h0000_0004);
        quiet("t6_quiet", 40);
        check("t6_irq", irq_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
